// File: rtl/instr_ctrl.sv
// Instruction register and decode control.
// Captures fetched instructions, decodes flow/ALU ops, tracks loop and retire counts.
module instr_ctrl (
    input  logic       clk,
    input  logic       ctrl_reset_n,
    input  logic [3:0] addr,
    input  logic [7:0] instr_in,
    input  logic       flag_z,
    output logic       pc_reset,
    output logic       jmp,
    output logic       ban,
    output logic [3:0] addrJmp,
    output logic       stop,
    output logic       alu_en,
    output logic [2:0] alu_op,
    output logic [7:0] ir,
    output logic       ir_valid,
    output logic [3:0] ir_addr,
    output logic [3:0] lc,
    output logic [7:0] retire_cnt
);

    localparam logic [3:0] OP_JMP   = 4'h1;
    localparam logic [3:0] OP_BR    = 4'h2;
    localparam logic [3:0] OP_BZ    = 4'h3;
    localparam logic [3:0] OP_SETLC = 4'h4;
    localparam logic [3:0] OP_LOOP  = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    logic [7:0] ir_q, ir_d;
    logic [3:0] ir_addr_q, ir_addr_d;
    logic       ir_valid_q, ir_valid_d;
    logic [3:0] lc_q, lc_d;
    logic [7:0] retire_cnt_q, retire_cnt_d;
    logic       stop_q, stop_d;
    logic       pc_reset_q, pc_reset_d;

    logic       dec_valid;
    logic [3:0] opcode;
    logic [3:0] imm;
    logic       take_jmp;
    logic       take_ban;
    logic       is_alu;
    logic       is_halt;

    // Decode the held instruction; everything is quiet unless it is live.
    always_comb begin
        opcode    = ir_q[7:4];
        imm       = ir_q[3:0];
        dec_valid = ir_valid_q && !stop_q;
        take_jmp  = 1'b0;
        take_ban  = 1'b0;
        is_alu    = 1'b0;
        is_halt   = 1'b0;
        if (dec_valid) begin
            take_jmp = (opcode == OP_JMP) ||
                       ((opcode == OP_LOOP) && (lc_q != 4'd0));
            take_ban = (opcode == OP_BR) ||
                       ((opcode == OP_BZ) && flag_z);
            is_alu   = opcode[3] && (opcode != OP_HALT);
            is_halt  = (opcode == OP_HALT);
        end
    end

    // Next-state: reset, startup bubble, halt freeze, or capture with squash.
    always_comb begin
        ir_d         = ir_q;
        ir_addr_d    = ir_addr_q;
        ir_valid_d   = 1'b0;
        lc_d         = lc_q;
        retire_cnt_d = retire_cnt_q;
        stop_d       = stop_q;
        pc_reset_d   = 1'b0;
        if (!ctrl_reset_n) begin
            ir_d         = 8'h00;
            ir_addr_d    = 4'd0;
            lc_d         = 4'd0;
            retire_cnt_d = 8'd0;
            stop_d       = 1'b0;
            pc_reset_d   = 1'b1;
        end else if (!stop_q && !pc_reset_q) begin
            ir_d       = instr_in;
            ir_addr_d  = addr;
            ir_valid_d = !(take_jmp || take_ban || is_halt);
            if (dec_valid) begin
                if (retire_cnt_q != 8'hFF)
                    retire_cnt_d = retire_cnt_q + 8'd1;
                if (opcode == OP_SETLC)
                    lc_d = imm;
                else if ((opcode == OP_LOOP) && (lc_q != 4'd0))
                    lc_d = lc_q - 4'd1;
                if (is_halt)
                    stop_d = 1'b1;
            end
        end
    end

    // State register with synchronous active-low reset folded into _d.
    always_ff @(posedge clk) begin
        ir_q         <= ir_d;
        ir_addr_q    <= ir_addr_d;
        ir_valid_q   <= ir_valid_d;
        lc_q         <= lc_d;
        retire_cnt_q <= retire_cnt_d;
        stop_q       <= stop_d;
        pc_reset_q   <= pc_reset_d;
    end

    assign jmp        = take_jmp;
    assign ban        = take_ban;
    assign addrJmp    = (take_jmp || take_ban) ? imm : 4'd0;
    assign alu_en     = is_alu;
    assign alu_op     = is_alu ? ir_q[6:4] : 3'd0;
    assign stop       = stop_q;
    assign pc_reset   = pc_reset_q;
    assign ir         = ir_q;
    assign ir_valid   = ir_valid_q;
    assign ir_addr    = ir_addr_q;
    assign lc         = lc_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_instr_ctrl.sv
// Bench for instr_ctrl: vector table plus saturation run,
// expected outputs queued at drive time and compared after each negedge.
module tb_instr_ctrl;

    logic       clk = 1'b0;
    logic       ctrl_reset_n;
    logic [3:0] addr;
    logic [7:0] instr_in;
    logic       flag_z;
    logic       pc_reset, jmp, ban, stop, alu_en, ir_valid;
    logic [3:0] addrJmp, ir_addr, lc;
    logic [2:0] alu_op;
    logic [7:0] ir, retire_cnt;

    instr_ctrl dut (
        .clk(clk), .ctrl_reset_n(ctrl_reset_n), .addr(addr),
        .instr_in(instr_in), .flag_z(flag_z), .pc_reset(pc_reset),
        .jmp(jmp), .ban(ban), .addrJmp(addrJmp), .stop(stop),
        .alu_en(alu_en), .alu_op(alu_op), .ir(ir), .ir_valid(ir_valid),
        .ir_addr(ir_addr), .lc(lc), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] a;
        logic [7:0] ins;
        logic       fz;
        logic       chk;
        logic       pcr;
        logic       stp;
        logic       v;
        logic [7:0] ir;
        logic       j;
        logic       b;
        logic [3:0] aj;
        logic       ae;
        logic [2:0] op;
        logic [3:0] lc;
        logic [7:0] ret;
    } vec_t;

    vec_t tbl[25];
    vec_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   tag = 0;

    function automatic vec_t mk(
        logic r, logic [3:0] a, logic [7:0] ins, logic fz, logic c,
        logic pcr, logic stp, logic v, logic [7:0] irv, logic j,
        logic b, logic [3:0] aj, logic ae, logic [2:0] op,
        logic [3:0] l, logic [7:0] ret);
        vec_t t;
        t.rst_n = r; t.a = a; t.ins = ins; t.fz = fz; t.chk = c;
        t.pcr = pcr; t.stp = stp; t.v = v; t.ir = irv; t.j = j;
        t.b = b; t.aj = aj; t.ae = ae; t.op = op; t.lc = l; t.ret = ret;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        @(negedge clk);
        ctrl_reset_n = t.rst_n;
        addr         = t.a;
        instr_in     = t.ins;
        flag_z       = t.fz;
        if (t.chk) sb.push_back(t);
    endtask

    // Compare each queued expectation against the outputs after inputs settle.
    always @(negedge clk) begin
        #1;
        while (sb.size() > 0) begin
            vec_t e;
            logic [40:0] got, req;
            e = sb.pop_front();
            got = {pc_reset, stop, ir_valid, ir, jmp, ban, addrJmp,
                   alu_en, alu_op, lc, retire_cnt};
            req = {e.pcr, e.stp, e.v, e.ir, e.j, e.b, e.aj,
                   e.ae, e.op, e.lc, e.ret};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL vec%0d actual=%h required=%h", tag, got, req);
            end
            tag++;
        end
    end

    initial begin
        vec_t t;
        logic [7:0] prev;
        int k;
        ctrl_reset_n = 1'b0;
        addr = 4'd0;
        instr_in = 8'h00;
        flag_z = 1'b0;

        //          r a    ins   fz c  pcr stp v ir    j b aj   ae op   lc   ret
        tbl[0]  = mk(0,4'h0,8'h00,0,0, 0,0,0,8'h00,0,0,4'h0,0,3'd0,4'd0,8'd0);
        tbl[1]  = mk(0,4'h0,8'h00,0,1, 1,0,0,8'h00,0,0,4'h0,0,3'd0,4'd0,8'd0);
        tbl[2]  = mk(1,4'h0,8'h1A,0,1, 1,0,0,8'h00,0,0,4'h0,0,3'd0,4'd0,8'd0);
        tbl[3]  = mk(1,4'h1,8'h1A,0,1, 0,0,0,8'h00,0,0,4'h0,0,3'd0,4'd0,8'd0);
        tbl[4]  = mk(1,4'h2,8'h77,0,1, 0,0,1,8'h1A,1,0,4'hA,0,3'd0,4'd0,8'd0);
        tbl[5]  = mk(1,4'hA,8'h33,0,1, 0,0,0,8'h77,0,0,4'h0,0,3'd0,4'd0,8'd1);
        tbl[6]  = mk(1,4'hB,8'h33,0,1, 0,0,1,8'h33,0,0,4'h0,0,3'd0,4'd0,8'd1);
        tbl[7]  = mk(1,4'hC,8'h42,1,1, 0,0,1,8'h33,0,1,4'h3,0,3'd0,4'd0,8'd2);
        tbl[8]  = mk(1,4'h3,8'h42,0,1, 0,0,0,8'h42,0,0,4'h0,0,3'd0,4'd0,8'd3);
        tbl[9]  = mk(1,4'h4,8'h55,0,1, 0,0,1,8'h42,0,0,4'h0,0,3'd0,4'd0,8'd3);
        tbl[10] = mk(1,4'h5,8'h00,0,1, 0,0,1,8'h55,1,0,4'h5,0,3'd0,4'd2,8'd4);
        tbl[11] = mk(1,4'h5,8'h55,0,1, 0,0,0,8'h00,0,0,4'h0,0,3'd0,4'd1,8'd5);
        tbl[12] = mk(1,4'h6,8'h55,0,1, 0,0,1,8'h55,1,0,4'h5,0,3'd0,4'd1,8'd5);
        tbl[13] = mk(1,4'h5,8'h55,0,1, 0,0,0,8'h55,0,0,4'h0,0,3'd0,4'd0,8'd6);
        tbl[14] = mk(1,4'h6,8'h9C,0,1, 0,0,1,8'h55,0,0,4'h0,0,3'd0,4'd0,8'd6);
        tbl[15] = mk(1,4'h7,8'hF0,0,1, 0,0,1,8'h9C,0,0,4'h0,1,3'd1,4'd0,8'd7);
        tbl[16] = mk(1,4'h8,8'h1A,0,1, 0,0,1,8'hF0,0,0,4'h0,0,3'd0,4'd0,8'd8);
        tbl[17] = mk(1,4'h9,8'h2B,1,1, 0,1,0,8'h1A,0,0,4'h0,0,3'd0,4'd0,8'd9);
        tbl[18] = mk(1,4'hA,8'h8F,1,1, 0,1,0,8'h1A,0,0,4'h0,0,3'd0,4'd0,8'd9);
        tbl[19] = mk(1,4'hB,8'h33,1,1, 0,1,0,8'h1A,0,0,4'h0,0,3'd0,4'd0,8'd9);
        tbl[20] = mk(0,4'h0,8'h00,0,1, 0,1,0,8'h1A,0,0,4'h0,0,3'd0,4'd0,8'd9);
        tbl[21] = mk(1,4'h0,8'h00,0,1, 1,0,0,8'h00,0,0,4'h0,0,3'd0,4'd0,8'd0);
        tbl[22] = mk(1,4'h0,8'h1A,0,1, 0,0,0,8'h00,0,0,4'h0,0,3'd0,4'd0,8'd0);
        tbl[23] = mk(0,4'h0,8'h44,0,1, 0,0,1,8'h1A,1,0,4'hA,0,3'd0,4'd0,8'd0);
        tbl[24] = mk(1,4'h0,8'h00,0,1, 1,0,0,8'h00,0,0,4'h0,0,3'd0,4'd0,8'd0);

        for (int i = 0; i < 25; i++) drive(tbl[i]);

        // Long ALU run: issue every cycle, retire count saturates.
        t = mk(1,4'h0,8'h90,0,1, 0,0,0,8'h00,0,0,4'h0,0,3'd0,4'd0,8'd0);
        drive(t);
        prev = 8'h90;
        for (int i = 1; i < 262; i++) begin
            k = (i - 1 > 255) ? 255 : i - 1;
            t = mk(1, i[3:0], {4'h9, i[3:0]}, i[0], 1,
                   0, 0, 1, prev, 0, 0, 4'h0, 1, 3'd1, 4'd0, k[7:0]);
            drive(t);
            prev = t.ins;
        end

        @(negedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
